// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// multi-cycle EX holds with timeout, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mc_busy,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned MC_CNT_W = $clog2(MC_TIMEOUT + 1);

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [MC_CNT_W-1:0] mc_cnt;
    logic [MC_CNT_W-1:0] mc_cnt_nxt;
    logic                load_use;
    logic                flush_inc;
    logic                timeout_set;

    // x0 is hard-wired zero, so a load targeting it can never be a producer.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // Next state and same-cycle pipeline controls; reset forces a free-running pipeline.
    always_comb begin
        state_nxt   = state;
        mc_cnt_nxt  = mc_cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        mc_busy     = 1'b0;
        flush_inc   = 1'b0;
        timeout_set = 1'b0;

        if (reset) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                        flush_inc  = 1'b1;
                    end else if (ex_mc_start) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b0;
                        state_nxt   = MC_WAIT;
                        mc_cnt_nxt  = MC_CNT_W'(1);
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b0;
                    end
                end
                MC_WAIT: begin
                    // Done wins over a coincident timeout, so the error flag stays clear.
                    if (mc_done || (mc_cnt == MC_CNT_W'(MC_TIMEOUT))) begin
                        state_nxt   = RUN;
                        mc_cnt_nxt  = '0;
                        timeout_set = !mc_done;
                    end else begin
                        mc_busy     = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b0;
                        mc_cnt_nxt  = mc_cnt + MC_CNT_W'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Saturating performance counters and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
            mc_timeout   <= 1'b0;
        end else begin
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
            if (timeout_set)
                mc_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares controls, counters and the timeout flag each cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MC_TIMEOUT = 8;

    // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy}
    localparam logic [6:0] C_NORM = 7'b111_111_0;
    localparam logic [6:0] C_LU   = 7'b001_101_0;
    localparam logic [6:0] C_BR   = 7'b111_001_0;
    localparam logic [6:0] C_MCS  = 7'b000_110_0;
    localparam logic [6:0] C_WAIT = 7'b000_110_1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             ex_mc_start;
    logic             mc_done;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mc_busy;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    typedef struct {
        string            tag;
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             to;
    } exp_t;

    exp_t       sbq[$];
    exp_t       cur;
    logic [6:0] act;
    int         vectors     = 0;
    int         miscompares = 0;

    pipeline_hazard_ctrl #(
        .CNT_W      (CNT_W),
        .MC_TIMEOUT (MC_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .mc_done         (mc_done),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .mc_busy         (mc_busy),
        .mc_timeout      (mc_timeout),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue what the negedge must show.
    task automatic cyc(input string tag,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic mr,
                       input logic [4:0] rd, input logic br, input logic mcs,
                       input logic done, input logic [6:0] ec,
                       input int es, input int ef, input logic et);
        exp_t e;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs1     = u1;
        id_uses_rs2     = u2;
        ex_mem_read     = mr;
        ex_rd           = rd;
        ex_branch_taken = br;
        ex_mc_start     = mcs;
        mc_done         = done;
        e.tag   = tag;
        e.ctrl  = ec;
        e.stall = CNT_W'(es);
        e.flush = CNT_W'(ef);
        e.to    = et;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [6:0] ec,
                        input int es, input int ef, input logic et);
        cyc(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ec, es, ef, et);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            act = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy};
            vectors++;
            if (act !== cur.ctrl || stall_cycles !== cur.stall ||
                flush_events !== cur.flush || mc_timeout !== cur.to) begin
                miscompares++;
                $display("FAIL %s: got ctrl=%b stall=%0d flush=%0d to=%b, want ctrl=%b stall=%0d flush=%0d to=%b",
                         cur.tag, act, stall_cycles, flush_events, mc_timeout,
                         cur.ctrl, cur.stall, cur.flush, cur.to);
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle("pre", C_NORM, 0, 0, 1'b0);
        sbq.delete();
        @(posedge clk);
        #1;
        // Reset dominates even with hazard inputs present.
        cyc("reset_hold", 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM, 0, 0, 1'b0);
        reset = 1'b1;
        idle("idle0", C_NORM, 0, 0, 1'b0);

        // Load-use via rs2, then clears once the load leaves EX.
        cyc("lu_rs2",   5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,   0, 0, 1'b0);
        cyc("lu_clear", 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM, 1, 0, 1'b0);
        cyc("lu_rs1",   5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_LU,   1, 0, 1'b0);
        // x0 destination and unused operand never stall.
        cyc("x0",       5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2, 0, 1'b0);
        cyc("unused",   5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, 2, 0, 1'b0);
        // Branch beats load-use and multi-cycle start.
        cyc("br_lu",    5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR,   2, 0, 1'b0);
        cyc("br_mc",    5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_BR,   2, 1, 1'b0);
        idle("br_after", C_NORM, 2, 2, 1'b0);

        // Multi-cycle op: 5 wait cycles, release on done; other inputs ignored while waiting.
        cyc("mc_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MCS,  2, 2, 1'b0);
        idle("mc_w1", C_WAIT, 3, 2, 1'b0);
        cyc("mc_w2_br", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_WAIT, 4, 2, 1'b0);
        cyc("mc_w3_lu", 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, C_WAIT, 5, 2, 1'b0);
        cyc("mc_w4_ms", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_WAIT, 6, 2, 1'b0);
        idle("mc_w5", C_WAIT, 7, 2, 1'b0);
        cyc("mc_done",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_NORM, 8, 2, 1'b0);
        idle("mc_after", C_NORM, 8, 2, 1'b0);
        cyc("run_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_NORM, 8, 2, 1'b0);
        idle("run_after", C_NORM, 8, 2, 1'b0);

        // Done coincident with timeout: released as done, flag stays clear; stall saturates.
        cyc("sim_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MCS, 8, 2, 1'b0);
        for (int i = 0; i < 7; i++)
            idle("sim_wait", C_WAIT, 9 + i, 2, 1'b0);
        cyc("sim_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_NORM, 15, 2, 1'b0);
        idle("sim_after", C_NORM, 15, 2, 1'b0);

        // Timeout: forced release on the MC_TIMEOUT-th wait cycle, sticky flag.
        cyc("to_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MCS, 15, 2, 1'b0);
        for (int i = 0; i < 7; i++)
            idle("to_wait", C_WAIT, 15, 2, 1'b0);
        idle("to_release", C_NORM, 15, 2, 1'b0);
        idle("to_sticky", C_NORM, 15, 2, 1'b1);
        cyc("to_lu",    5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU, 15, 2, 1'b1);
        idle("to_sticky2", C_NORM, 15, 2, 1'b1);

        // Flush counter saturation.
        for (int i = 0; i < 14; i++)
            cyc("br_sat", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR, 15, 2 + i, 1'b1);
        idle("br_sat_a", C_NORM, 15, 15, 1'b1);
        cyc("br_sat_b", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR, 15, 15, 1'b1);
        idle("br_sat_c", C_NORM, 15, 15, 1'b1);

        // Asynchronous reset mid-MC_WAIT, then a late done is ignored.
        cyc("rst_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MCS, 15, 15, 1'b1);
        idle("rst_w1", C_WAIT, 15, 15, 1'b1);
        idle("rst_w2", C_WAIT, 15, 15, 1'b1);
        reset = 1'b0;
        cyc("rst_mid",  5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, C_NORM, 0, 0, 1'b0);
        reset = 1'b1;
        cyc("late_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_NORM, 0, 0, 1'b0);
        idle("post_rst", C_NORM, 0, 0, 1'b0);
        cyc("post_lu",  5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_LU, 0, 0, 1'b0);
        idle("post_end", C_NORM, 1, 0, 1'b0);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
